unrotate_buffer: RTL and testbench

Streaming inverse of the 4x4 byte-matrix rotation stage. It accepts a rotated 16-byte block serially, buffers it, and emits the original (un-rotated) block serially in row-major order, so the Enigma pipeline can decrypt what the rotate stage scrambled. It sits between the byte-stream source (the cipher core output) and the block consumer, with valid/ready handshakes on both sides.

---
 rtl/unrotate_buffer.sv | 148 ++++++++++++++
 tb/tb_unrotate_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unrotate_buffer.sv
// Streaming inverse of the 4x4 byte-matrix rotation: buffers a rotated 16-byte block and replays it un-rotated.
// Optional UNROTATE_PINGPONG_EN builds two banks so fill and drain overlap; undefined builds a single FILL/DRAIN bank.
module unrotate_buffer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_dir,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              blk_done
);

   // Buffer index of received byte R[r][c] that becomes output position n = 4i+j.
   function automatic logic [3:0] src_idx(input logic dir, input logic [3:0] n);
      logic [1:0] i;
      logic [1:0] j;
      i = n[3:2];
      j = n[1:0];
      return dir ? {2'd3 - j, i} : {j, 2'd3 - i};
   endfunction

   logic       in_hs;
   logic       out_hs;
   logic [3:0] wcnt;
   logic [3:0] rcnt;

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

`ifdef UNROTATE_PINGPONG_EN

   logic [DATA_W-1:0] mem [2][16];
   logic [1:0]        full;
   logic [1:0]        dir_q;
   logic              wbank;
   logic              rbank;
   logic              run;

   assign in_ready  = run && !full[wbank];
   assign out_valid = full[rbank];
   assign out_data  = out_valid ? mem[rbank][src_idx(dir_q[rbank], rcnt)] : '0;
   assign out_last  = out_valid && (rcnt == 4'd15);

   // Fill completion and drain completion always target different banks, so both may land on one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned b = 0; b < 2; b++)
            for (int unsigned k = 0; k < 16; k++)
               mem[b][k] <= '0;
         full     <= '0;
         dir_q    <= '0;
         wbank    <= 1'b0;
         rbank    <= 1'b0;
         run      <= 1'b0;
         wcnt     <= '0;
         rcnt     <= '0;
         blk_done <= 1'b0;
      end else begin
         run      <= 1'b1;
         blk_done <= 1'b0;
         if (in_hs) begin
            mem[wbank][wcnt] <= in_data;
            wcnt             <= wcnt + 4'd1;
            if (wcnt == 4'd0)
               dir_q[wbank] <= in_dir;
            if (wcnt == 4'd15) begin
               full[wbank] <= 1'b1;
               wbank       <= ~wbank;
            end
         end
         if (out_hs) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
               full[rbank] <= 1'b0;
               rbank       <= ~rbank;
               blk_done    <= 1'b1;
            end
         end
      end
   end

`else

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] mem [16];
   logic              dir_q;

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE:    state_next = FILL;
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && wcnt == 4'd15)
               state_next = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && rcnt == 4'd15)
               state_next = FILL;
         end
         default: state_next = IDLE;
      endcase
   end

   assign out_data = out_valid ? mem[src_idx(dir_q, rcnt)] : '0;
   assign out_last = out_valid && (rcnt == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         for (int unsigned k = 0; k < 16; k++)
            mem[k] <= '0;
         dir_q    <= 1'b0;
         wcnt     <= '0;
         rcnt     <= '0;
         blk_done <= 1'b0;
      end else begin
         state    <= state_next;
         blk_done <= 1'b0;
         if (in_hs) begin
            mem[wcnt] <= in_data;
            wcnt      <= wcnt + 4'd1;
            if (wcnt == 4'd0)
               dir_q <= in_dir;
         end
         if (out_hs) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15)
               blk_done <= 1'b1;
         end
      end
   end

`endif

endmodule

// File: tb/tb_unrotate_buffer.sv
// Scoreboard bench for unrotate_buffer: stimulus pushes model-derived expected bytes, a monitor pops on each output handshake.
module tb_unrotate_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_dir;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       blk_done;

   typedef logic [7:0] blk_t [16];
   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         passed = 0;
   int         obyte = 0;
   int         lowcnt = 0;
   int         rmode = 0;
   bit         meas = 1'b0;
   bit         done_exp = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   unrotate_buffer #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .blk_done  (blk_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: undoing rotate-right is one counter-clockwise quarter turn, undoing rotate-left is three.
   function automatic void model(input blk_t r, input logic dir, output blk_t o);
      logic [7:0] m [4][4];
      logic [7:0] t [4][4];
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            m[i][j] = r[4*i+j];
      for (int s = 0; s < (dir ? 3 : 1); s++) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               t[i][j] = m[j][3-i];
         m = t;
      end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            o[4*i+j] = m[i][j];
   endfunction

   task automatic push_exp(input blk_t o);
      for (int n = 0; n < 16; n++)
         q.push_back(exp_t'{data: o[n], last: (n == 15)});
   endtask

   // tmode: 0 = steady in_dir, 1 = inverted in_dir on bytes 1..15, 2 = random in_dir on bytes 1..15
   task automatic send_block(input blk_t d, input logic dir, input int tmode, input bit gaps);
      int b;
      for (int k = 0; k < 16; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_dir   = 1'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = d[k];
         if (k == 0 || tmode == 0) in_dir = dir;
         else if (tmode == 1)      in_dir = ~dir;
         else                      in_dir = 1'($urandom);
         b = 0;
         while (!in_ready && b < 300) begin
            @(posedge clk); #1;
            b++;
         end
         if (!in_ready) begin
            chk("in_ready_timeout", 32'(b), 32'(0));
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int b = 0;
      while (q.size() != 0 && b < 600) begin
         @(posedge clk); #1;
         b++;
      end
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Output-side flow control.
   initial begin
      int stall = 0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (obyte == 7 && out_valid) begin
                  if (stall < 5) begin
                     out_ready = 1'b0;
                     stall++;
                  end else out_ready = 1'b1;
               end else begin
                  stall     = 0;
                  out_ready = 1'b1;
               end
            end
            default: out_ready = (obyte < 9);
         endcase
      end
   end

   // Monitor: sampled on the falling edge, away from the active edge.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            obyte      = 0;
            done_exp   = 1'b0;
            prev_stall = 1'b0;
         end else begin
            chk("blk_done", 32'(blk_done), 32'(done_exp));
            done_exp = 1'b0;
            if (prev_stall) begin
               chk("hold_valid", 32'(out_valid), 32'(1));
               chk("hold_data", 32'(out_data), 32'(prev_data));
               chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
               end else begin
                  x = q.pop_front();
                  chk("out_data", 32'(out_data), 32'(x.data));
                  chk("out_last", 32'(out_last), 32'(x.last));
                  obyte    = x.last ? 0 : obyte + 1;
                  done_exp = x.last;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (meas && !in_ready) lowcnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      blk_t seq, e0, e1, rt, r, o;
      int   l0, b;
      logic dir;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
      for (int k = 0; k < 16; k++) seq[k] = 8'(k);
      e0 = '{8'h03, 8'h07, 8'h0B, 8'h0F, 8'h02, 8'h06, 8'h0A, 8'h0E,
             8'h01, 8'h05, 8'h09, 8'h0D, 8'h00, 8'h04, 8'h08, 8'h0C};
      e1 = '{8'h0C, 8'h08, 8'h04, 8'h00, 8'h0D, 8'h09, 8'h05, 8'h01,
             8'h0E, 8'h0A, 8'h06, 8'h02, 8'h0F, 8'h0B, 8'h07, 8'h03};
      rt = e1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_data", 32'(out_data), 32'(0));
      chk("rst_out_last", 32'(out_last), 32'(0));
      chk("rst_blk_done", 32'(blk_done), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'(1));

      // Directed vectors.
      push_exp(e0); send_block(seq, 1'b0, 0, 1'b0); wait_drain();
      push_exp(e1); send_block(seq, 1'b1, 0, 1'b0); wait_drain();
      push_exp(seq); send_block(rt, 1'b0, 1, 1'b0); wait_drain();

      // Backpressure at output byte 7.
      rmode = 2;
      push_exp(e0); send_block(seq, 1'b0, 0, 1'b0); wait_drain();
      rmode = 0;

      // Reset after 9 output bytes.
      rmode = 3;
      for (int k = 0; k < 16; k++) r[k] = 8'($urandom);
      dir = 1'($urandom);
      model(r, dir, o); push_exp(o);
      send_block(r, dir, 0, 1'b0);
      b = 0;
      while (obyte != 9 && b < 300) begin
         @(posedge clk); #1;
         b++;
      end
      if (obyte != 9) chk("reset_wait_timeout", 32'(obyte), 32'(9));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_out_data", 32'(out_data), 32'(0));
      chk("midrst_blk_done", 32'(blk_done), 32'(0));
      rmode = 0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_in_ready", 32'(in_ready), 32'(1));
      push_exp(e1); send_block(seq, 1'b1, 0, 1'b0); wait_drain();

      // Throughput: four back-to-back blocks, continuous handshakes.
      meas = 1'b1;
      l0 = lowcnt;
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < 16; k++) r[k] = 8'($urandom);
         dir = 1'($urandom);
         model(r, dir, o); push_exp(o);
         send_block(r, dir, 0, 1'b0);
      end
      wait_drain();
      meas = 1'b0;
`ifdef UNROTATE_PINGPONG_EN
      chk("in_ready_low_cycles", 32'(lowcnt - l0), 32'(0));
`else
      chk("in_ready_low_cycles", 32'(lowcnt - l0), 32'(64));
`endif

      // Randomized blocks with input gaps, random in_dir noise and random output stalls.
      rmode = 1;
      for (int n = 0; n < 12; n++) begin
         for (int k = 0; k < 16; k++) r[k] = 8'($urandom);
         dir = 1'($urandom);
         model(r, dir, o); push_exp(o);
         send_block(r, dir, 2, 1'b1);
      end
      wait_drain();
      rmode = 0;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
